// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 decrypt path.
// Latency: n/a (types only).
// Backpressure: n/a.
package arc4_pkg;

    localparam int BYTE_W    = 8;
    localparam int MEM_DEPTH = 256;

    typedef logic [BYTE_W-1:0] byte_t;

    // One state per cycle of the PRGA schedule; *_A issue an address,
    // *_W wait out the synchronous read, *_L latch the returned byte.
    typedef enum logic [3:0] {
        IDLE,
        LEN_A,
        LEN_W,
        LEN_L,
        SI_A,
        SI_W,
        SI_L,
        SJ_A,
        SJ_W,
        SJ_L,
        WR_I,
        WR_J,
        PAD_A,
        PAD_W,
        PT_WR
    } prga_state_t;

endpackage

// File: rtl/prga_if.sv
// Bus bundle between the PRGA stage and its S/CT/PT memories plus start handshake.
// Latency: n/a (wiring only).
// Backpressure: en is only honoured while rdy=1; memories are never stalled.
// Ports: en/rdy start handshake; s_* S memory (r/w); ct_* CT memory (read); pt_* PT memory (write).
interface prga_if;
    import arc4_pkg::*;

    logic  en;
    logic  rdy;
    byte_t s_addr;
    byte_t s_rddata;
    byte_t s_wrdata;
    logic  s_wren;
    byte_t ct_addr;
    byte_t ct_rddata;
    byte_t pt_addr;
    byte_t pt_wrdata;
    logic  pt_wren;

    // master: the PRGA engine, which drives addresses and write strobes
    modport master (
        input  en, s_rddata, ct_rddata,
        output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );

    // slave: the memories and the controller that requests a run
    modport slave (
        output en, s_rddata, ct_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );

endinterface

// File: rtl/prga.sv
// RC4 keystream stage: decrypts length-prefixed CT into PT, swapping S in place.
// Latency: 3 cycles + 11 cycles per byte from the accepting edge back to rdy=1.
// Backpressure: none downstream; en is ignored while a run is in progress (rdy=0).
// Ports: clk, rst_n (async active-low); bus (prga_if.master) carrying en/rdy and S/CT/PT memory ports.
module prga
    import arc4_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    prga_if.master   bus
);

    prga_state_t r_state, w_next;

    byte_t r_i, r_j, r_k, r_len, r_si, r_sj;

    // Address/data outputs hold their last driven value in states that do
    // not drive them, so these registers track whatever was last presented.
    byte_t r_s_addr, r_s_wrdata, r_ct_addr, r_pt_addr, r_pt_wrdata;

    logic  w_rdy, w_s_wren, w_pt_wren;
    byte_t w_s_addr, w_s_wrdata, w_ct_addr, w_pt_addr, w_pt_wrdata;

    always_comb begin
        w_next      = r_state;
        w_rdy       = 1'b0;
        w_s_wren    = 1'b0;
        w_pt_wren   = 1'b0;
        w_s_addr    = r_s_addr;
        w_s_wrdata  = r_s_wrdata;
        w_ct_addr   = r_ct_addr;
        w_pt_addr   = r_pt_addr;
        w_pt_wrdata = r_pt_wrdata;

        case (r_state)
            IDLE: begin
                w_rdy = 1'b1;
                if (bus.en) w_next = LEN_A;
            end
            LEN_A: begin
                w_ct_addr = '0;
                w_next    = LEN_W;
            end
            LEN_W: w_next = LEN_L;
            LEN_L: begin
                // Length byte is copied straight through to pt[0].
                w_pt_addr   = '0;
                w_pt_wrdata = bus.ct_rddata;
                w_pt_wren   = 1'b1;
                w_next      = (bus.ct_rddata == '0) ? IDLE : SI_A;
            end
            SI_A: begin
                w_s_addr = r_i + 8'd1;
                w_next   = SI_W;
            end
            SI_W: w_next = SI_L;
            SI_L: w_next = SJ_A;
            SJ_A: begin
                w_s_addr = r_j;
                w_next   = SJ_W;
            end
            SJ_W: w_next = SJ_L;
            SJ_L: w_next = WR_I;
            WR_I: begin
                w_s_addr   = r_i;
                w_s_wrdata = r_sj;
                w_s_wren   = 1'b1;
                w_next     = WR_J;
            end
            WR_J: begin
                // When i==j this rewrites the same cell with its own value.
                w_s_addr   = r_j;
                w_s_wrdata = r_si;
                w_s_wren   = 1'b1;
                w_next     = PAD_A;
            end
            PAD_A: begin
                w_s_addr  = r_si + r_sj;
                w_ct_addr = r_k;
                w_next    = PAD_W;
            end
            PAD_W: w_next = PT_WR;
            PT_WR: begin
                w_pt_addr   = r_k;
                w_pt_wrdata = bus.s_rddata ^ bus.ct_rddata;
                w_pt_wren   = 1'b1;
                w_next      = (r_k == r_len) ? IDLE : SI_A;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_len       <= '0;
            r_si        <= '0;
            r_sj        <= '0;
            r_s_addr    <= '0;
            r_s_wrdata  <= '0;
            r_ct_addr   <= '0;
            r_pt_addr   <= '0;
            r_pt_wrdata <= '0;
        end else begin
            r_s_addr    <= w_s_addr;
            r_s_wrdata  <= w_s_wrdata;
            r_ct_addr   <= w_ct_addr;
            r_pt_addr   <= w_pt_addr;
            r_pt_wrdata <= w_pt_wrdata;

            case (r_state)
                IDLE: begin
                    if (bus.en) begin
                        r_i <= '0;
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                LEN_L: begin
                    r_len <= bus.ct_rddata;
                    r_k   <= 8'd1;
                end
                SI_A: r_i <= r_i + 8'd1;
                SI_L: begin
                    r_si <= bus.s_rddata;
                    r_j  <= r_j + bus.s_rddata;
                end
                SJ_L: r_sj <= bus.s_rddata;
                PT_WR: begin
                    // k stops at L (max 255) so it never wraps.
                    if (r_k != r_len) r_k <= r_k + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rdy       = w_rdy;
    assign bus.s_addr    = w_s_addr;
    assign bus.s_wrdata  = w_s_wrdata;
    assign bus.s_wren    = w_s_wren;
    assign bus.ct_addr   = w_ct_addr;
    assign bus.pt_addr   = w_pt_addr;
    assign bus.pt_wrdata = w_pt_wrdata;
    assign bus.pt_wren   = w_pt_wren;

endmodule
